// File: rtl/gfx_pkg.sv
// gfx_pkg: opcode and FSM state encodings shared by the blitter block
package gfx_pkg;
   localparam logic [1:0] OP_FILL       = 2'd0;
   localparam logic [1:0] OP_COPY       = 2'd1;
   localparam logic [1:0] OP_COPY_KEYED = 2'd2;
   localparam logic [1:0] OP_NOP        = 2'd3;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
endpackage

// File: rtl/gfx_raster_walker.sv
// gfx_raster_walker: raster x/y scan with an accumulated, multiplier-free VRAM address
module gfx_raster_walker #(
   parameter int SCREEN_W = 640,
   parameter int VRAM_AW  = 19
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic [9:0]         tl_x,
   input  logic [9:0]         br_x,
   input  logic [8:0]         tl_y,
   input  logic [8:0]         br_y,
   input  logic [VRAM_AW-1:0] start_addr,
   output logic [VRAM_AW-1:0] addr,
   output logic               x_last,
   output logic               last
);
   logic [9:0]         x, x0, x1;
   logic [8:0]         y, y1;
   logic [VRAM_AW-1:0] row;
   assign x_last = x == x1;
   assign last   = x_last && y == y1;
   // latch bounds and start address on load, then advance one pixel per step
   always_ff @(posedge clk)
      if (rst) begin
         x    <= '0;
         x0   <= '0;
         x1   <= '0;
         y    <= '0;
         y1   <= '0;
         row  <= '0;
         addr <= '0;
      end else if (load) begin
         x    <= tl_x;
         x0   <= tl_x;
         x1   <= br_x;
         y    <= tl_y;
         y1   <= br_y;
         row  <= start_addr;
         addr <= start_addr;
      end else if (step) begin
         x    <= x_last ? x0 : x + 10'd1;
         y    <= x_last ? y + 9'd1 : y;
         row  <= x_last ? row + VRAM_AW'(SCREEN_W) : row;
         addr <= x_last ? row + VRAM_AW'(SCREEN_W) : addr + 1'b1;
      end
endmodule

// File: rtl/gfx_blitter.sv
// gfx_blitter: rectangle FILL / COPY / COPY_KEYED engine writing one pixel per cycle to VRAM
module gfx_blitter import gfx_pkg::*; #(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int PIX_W    = 12,
   parameter int ROM_AW   = 16,
   parameter int VRAM_AW  = 19
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      cmd_valid,
   output logic                                      cmd_ready,
   input  logic [1:0]                                cmd_op,
   input  logic [9:0]                                cmd_tl_x,
   input  logic [9:0]                                cmd_br_x,
   input  logic [8:0]                                cmd_tl_y,
   input  logic [8:0]                                cmd_br_y,
   input  logic [(PIX_W > ROM_AW ? PIX_W : ROM_AW)-1:0] cmd_arg,
   input  logic [PIX_W-1:0]                          cmd_key,
   output logic [ROM_AW-1:0]                         rom_addr,
   input  logic [PIX_W-1:0]                          rom_data,
   output logic                                      vram_we,
   output logic [VRAM_AW-1:0]                        vram_addr,
   output logic [PIX_W-1:0]                          vram_data,
   output logic                                      busy,
   output logic                                      done
);
   localparam int ARG_W = PIX_W > ROM_AW ? PIX_W : ROM_AW;
   logic [2:0]         state, nxt;
   logic [1:0]         op;
   logic [9:0]         tl_x, br_x, cbr_x;
   logic [8:0]         tl_y, br_y, cbr_y;
   logic [ARG_W-1:0]   arg;
   logic [PIX_W-1:0]   key;
   logic [VRAM_AW-1:0] start_addr, walk_addr, pipe_addr;
   logic [ROM_AW-1:0]  src_addr, src_row, stride;
   logic               empty, x_last, last, pipe_v, fill_we, hit;
   assign cbr_x      = br_x > 10'(SCREEN_W - 1) ? 10'(SCREEN_W - 1) : br_x;
   assign cbr_y      = br_y > 9'(SCREEN_H - 1) ? 9'(SCREEN_H - 1) : br_y;
   assign empty      = tl_x > cbr_x || tl_y > cbr_y;
   assign start_addr = VRAM_AW'(tl_y) * VRAM_AW'(SCREEN_W) + VRAM_AW'(tl_x);
   assign stride     = ROM_AW'({1'b0, br_x} - {1'b0, tl_x} + 11'd1);
   // command sequencing: IDLE -> SETUP -> RUN -> (DRAIN) -> DONE -> IDLE
   always_comb
      nxt = state == ST_IDLE  ? (cmd_valid ? ST_SETUP : ST_IDLE) :
            state == ST_SETUP ? (op == OP_NOP || empty ? ST_DONE : ST_RUN) :
            state == ST_RUN   ? (last ? (op == OP_FILL ? ST_DONE : ST_DRAIN) : ST_RUN) :
            state == ST_DRAIN ? ST_DONE : ST_IDLE;
   // state, command capture, source address walk and the one-stage COPY write pipeline
   always_ff @(posedge clk)
      if (rst) begin
         state     <= ST_IDLE;
         op        <= OP_NOP;
         tl_x      <= '0;
         br_x      <= '0;
         tl_y      <= '0;
         br_y      <= '0;
         arg       <= '0;
         key       <= '0;
         src_addr  <= '0;
         src_row   <= '0;
         pipe_v    <= 1'b0;
         pipe_addr <= '0;
      end else begin
         state     <= nxt;
         pipe_v    <= state == ST_RUN && op != OP_FILL;
         pipe_addr <= walk_addr;
         if (state == ST_IDLE && cmd_valid) begin
            op   <= cmd_op;
            tl_x <= cmd_tl_x;
            br_x <= cmd_br_x;
            tl_y <= cmd_tl_y;
            br_y <= cmd_br_y;
            arg  <= cmd_arg;
            key  <= cmd_key;
         end
         if (state == ST_SETUP) begin
            src_addr <= arg[ROM_AW-1:0];
            src_row  <= arg[ROM_AW-1:0];
         end else if (state == ST_RUN) begin
            src_addr <= x_last ? src_row + stride : src_addr + 1'b1;
            src_row  <= x_last ? src_row + stride : src_row;
         end
      end
   gfx_raster_walker #(.SCREEN_W(SCREEN_W), .VRAM_AW(VRAM_AW)) u_walker (
      .clk       (clk),
      .rst       (rst),
      .load      (state == ST_SETUP),
      .step      (state == ST_RUN),
      .tl_x      (tl_x),
      .br_x      (cbr_x),
      .tl_y      (tl_y),
      .br_y      (cbr_y),
      .start_addr(start_addr),
      .addr      (walk_addr),
      .x_last    (x_last),
      .last      (last)
   );
   assign fill_we   = state == ST_RUN && op == OP_FILL;
   assign hit       = op == OP_COPY_KEYED && rom_data == key;
   assign vram_we   = fill_we || (pipe_v && !hit);
   assign vram_addr = pipe_v ? pipe_addr : walk_addr;
   assign vram_data = pipe_v ? rom_data : fill_we ? arg[PIX_W-1:0] : '0;
   assign rom_addr  = src_addr;
   assign cmd_ready = state == ST_IDLE;
   assign busy      = state != ST_IDLE;
   assign done      = state == ST_DONE;
endmodule

// File: doc/gfx_blitter.md
GFX_BLITTER -- requirements
Module: gfx_blitter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, meaning screen width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 480, meaning screen height in pixels.
REQ-003 SHALL have parameter PIX_W, default 12, meaning pixel colour width.
REQ-004 SHALL have parameter ROM_AW, default 16, meaning sprite ROM address width.
REQ-005 SHALL have parameter VRAM_AW, default 19, meaning VRAM address width.
REQ-006 SHALL have ports, in this order:
- clk  in  1  sole clock; one clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0 FILL, 1 COPY, 2 COPY_KEYED, 3 NOP.
- cmd_tl_x / cmd_br_x  in  10  rectangle x bounds, inclusive.
- cmd_tl_y / cmd_br_y  in  9  rectangle y bounds, inclusive.
- cmd_arg  in  max(PIX_W,ROM_AW)  fill colour (FILL) or ROM base address (COPY*).
- cmd_key  in  PIX_W  transparent colour (COPY_KEYED).
- rom_addr  out  ROM_AW  sprite ROM address.
- rom_data  in  PIX_W  ROM data; valid one cycle after rom_addr.
- vram_we  out  1  VRAM write strobe.
- vram_addr  out  VRAM_AW  VRAM address.
- vram_data  out  PIX_W  VRAM write data.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at command completion.

Function
REQ-007 SHALL accept a command on the cycle where cmd_valid and cmd_ready are both high, and register all cmd_* fields on that cycle.
REQ-008 SHALL implement the states IDLE, SETUP, RUN, DRAIN and DONE with these transitions:
- IDLE to SETUP on accept.
- SETUP to RUN, or to DONE for NOP or an empty clipped rectangle.
- RUN to DRAIN after the last pixel for COPY*, or to DONE after the last pixel for FILL.
- DRAIN to DONE.
- DONE to IDLE.
REQ-009 SHALL clip in SETUP: clipped br_x = min(br_x, SCREEN_W-1); clipped br_y = min(br_y, SCREEN_H-1).
REQ-010 SHALL treat the rectangle as empty when tl_x > clipped br_x or tl_y > clipped br_y, producing no writes and only the done pulse.
REQ-011 SHALL compute vram_addr = tl_y*SCREEN_W + tl_x once, in SETUP only; in RUN, addresses advance by +1 per pixel and the row base advances by +SCREEN_W per row.
REQ-012 SHALL have no multiplier in the RUN path.
REQ-013 SHALL scan raster order (x inner, y outer) at one pixel per cycle in RUN.
REQ-014 SHALL, for FILL, assert vram_we in the same cycle as each RUN pixel, with vram_data = cmd_arg[PIX_W-1:0].
REQ-015 SHALL, for COPY*, present rom_addr in the RUN cycle and issue the matching VRAM write one cycle later.
REQ-016 SHALL delay the vram_addr of a COPY* write by one pipeline register so it aligns with rom_data.
REQ-017 SHALL set the source stride to the unclipped width (cmd_br_x - cmd_tl_x + 1).
REQ-018 SHALL start each source row at the previous source row base plus that stride, so right-edge clipping skips the clipped ROM words.
REQ-019 SHALL, for COPY_KEYED, deassert vram_we for a pixel whose rom_data equals cmd_key; addresses still advance.
REQ-020 SHALL compute every address modulo its port width, with no saturation.
REQ-021 SHALL assert done for exactly one cycle, in DONE.
REQ-022 SHALL meet this latency, for an accept at cycle t with N visible pixels:
- FILL: writes at t+2 .. t+1+N; done at t+2+N.
- COPY*: writes at t+3 .. t+2+N; done at t+3+N.
REQ-023 SHALL ignore cmd_valid while busy, so that no command is queued.
REQ-024 SHALL hold vram_we low outside RUN (FILL) and outside RUN+1 / DRAIN (COPY*).

Reset
REQ-025 SHALL, on rst high at a clock edge, enter IDLE from any state including mid-RUN, and abandon the command with no done pulse.
REQ-026 SHALL reset these outputs: cmd_ready=1, busy=0, done=0, vram_we=0, vram_addr=0, vram_data=0, rom_addr=0.
REQ-027 SHALL suppress any VRAM write in the cycle following a reset, including a pending COPY pipeline write.

Structure
REQ-028 SHALL place the opcode encodings (FILL, COPY, COPY_KEYED, NOP) and the state encodings in the shared package gfx_pkg.
REQ-029 SHALL implement the raster walker as a single sub-module, gfx_raster_walker (x/y counters, row-base accumulator, last-pixel flag); gfx_blitter contains the FSM, clipping, ROM pipeline and key compare.

Verification
REQ-030 SHALL cover FILL tl=(2,3), br=(4,4), arg=0xF00 -> six writes at addresses 1922, 1923, 1924, 2562, 2563, 2564, each with data 0xF00; done at t+8.
REQ-031 SHALL cover COPY tl=(0,0), br=(1,1), arg=0x0100, ROM[0x100..0x103]=A,B,C,D -> writes (0,A), (1,B), (640,C), (641,D); done at t+7.
REQ-032 SHALL cover COPY_KEYED as REQ-031 with ROM[0x101]=key=0x000 -> three writes, address 1 skipped, done timing unchanged.
REQ-033 SHALL cover COPY tl=(638,0), br=(641,1), arg=0 -> writes at 638 and 639 from ROM 0 and 1, then 1278 and 1279 from ROM 4 and 5; four writes total.
REQ-034 SHALL cover NOP, and FILL with tl=(700,10) -> no writes; done at t+2 for both.
REQ-035 SHALL cover rst asserted during the 3rd RUN cycle of a 100-pixel FILL -> no further writes, no done pulse, cmd_ready=1 on the next cycle; a new command is then accepted normally.
